tremolo_vca: RTL and testbench
==============================

Name: tremolo_vca

Overview:
Tremolo amplitude stage, directly downstream of the sine modulator. It takes the 9-bit unsigned LFO value and a user depth setting and derives a per-sample gain. That gain scales the signed audio stream.
- Depth is slewed one step per sample to avoid zipper noise.
- Datapath is a 3-stage valid-qualified pipeline sitting between the audio input path and the effect output mux.

Parameters:
DW, 16, signed audio sample width (both in and out)
MW, 9, modulator width; fixed at 9 to match the modulator, other values unsupported
DEPTH_W, 8, depth control width

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
sample_valid_i  input  1  input sample strobe, one cycle per sample, may be high on consecutive cycles
sample_i  input  DW  signed audio sample, qualified by sample_valid_i
modulator_i  input  MW  unsigned LFO value 0..511, sampled when sample_valid_i=1
depth_i  input  DEPTH_W  target modulation depth, 0 = none, 255 = maximum
bypass_i  input  1  1 = pass sample unchanged; sampled with sample_valid_i
sample_o  output  DW  signed processed sample
sample_valid_o  output  1  output strobe, one cycle per input sample

Behaviour:
Reset:
- rst_n_i low asynchronously clears all pipeline valid flags, sample_o=0, sample_valid_o=0 and depth_s=0.
- Release is synchronous to clk_i.
- A reset mid-stream discards in-flight samples; no partial outputs are produced.

Depth slew:
- Internal register depth_s (DEPTH_W bits) updates only on cycles with sample_valid_i=1.
- depth_s < depth_i: +1. depth_s > depth_i: -1. Equal: hold.
- The value used for a sample is depth_s before that cycle's update.

Stage 1 (cycle of sample_valid_i):
- Register sample, bypass flag and att = (depth_s * (511 - modulator_i)) >> 8.
- att is a 9-bit unsigned value; the product is 17 bits and is truncated.
- att range is 0..509.

Stage 2:
- gain = 511 - att, 9-bit unsigned, range 2..511. Register gain, sample and bypass.

Stage 3:
- prod = signed(sample) * signed({1'b0, gain}), DW+10 bits.
- sample_o = prod >>> 9: arithmetic shift, truncation toward -inf, no rounding.
- No saturation is needed because gain < 512.
- If bypass: sample_o = sample, bit exact.
- sample_valid_o = 1 for one cycle.

Latency and throughput:
- Exactly 3 clk_i cycles from sample_valid_i to sample_valid_o.
- Throughput is 1 sample/cycle; input gaps are reproduced exactly at the output.
- sample_o holds its last value while sample_valid_o=0.

Boundary conditions:
- modulator_i=511: gain=511 for any depth.
- depth_s=0: gain=511 for any modulator_i.
- bypass_i has no effect on the depth_s slew.
- depth_i changing every cycle: depth_s still moves at most 1 per valid sample.
- No backpressure; the consumer must accept every sample_valid_o.

Test Plan:
1. Bypass: bypass_i=1, sample_i=16'h4000, any modulator/depth -> sample_o=16'h4000 exactly 3 cycles later with sample_valid_o=1 for 1 cycle.
2. Zero depth: depth_i=0 after reset, modulator_i=0, sample_i=16384 -> gain 511, sample_o=16352. Same result with sample_i=-16384 -> -16352.
3. Full depth ramp: depth_i=255 from reset, 255 valid samples -> depth_s reaches 255 exactly on the 255th update. Next sample with modulator_i=0, sample_i=-32768 -> att=509, gain=2, sample_o=-128. With modulator_i=511 -> sample_o=-32704.
4. Slew down: depth_s=10, depth_i set to 5 -> depth_s takes 9, 8, 7, 6, 5 over the next 5 valid samples, then holds. Samples with sample_valid_i=0 cause no change.
5. Streaming: 10 samples back-to-back, then 3 samples with 2-cycle gaps -> 13 outputs in identical order and spacing, each delayed 3 cycles, values matching the reference model.
6. Reset mid-stream: assert rst_n_i low while 3 samples are in flight -> sample_valid_o=0 and sample_o=0 immediately without a clock edge. After release, no stale outputs appear and depth_s restarts from 0.

Source files
------------

// File: rtl/tremolo_vca.sv
// Tremolo amplitude stage: derives a per-sample gain from the LFO value and a
// slewed depth setting, then scales the signed audio stream. Three-stage
// valid-qualified pipeline with no backpressure.
module tremolo_vca #(
    parameter int unsigned DW      = 16,
    parameter int unsigned MW      = 9,
    parameter int unsigned DEPTH_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 sample_valid_i,
    input  logic [DW-1:0]        sample_i,
    input  logic [MW-1:0]        modulator_i,
    input  logic [DEPTH_W-1:0]   depth_i,
    input  logic                 bypass_i,
    output logic [DW-1:0]        sample_o,
    output logic                 sample_valid_o
);

    // Attenuation product is depth x inverted modulator, scaled back by 2^8.
    localparam int unsigned ATT_PROD_W = DEPTH_W + MW;
    localparam int unsigned ATT_SHIFT  = 8;
    // Gain is applied as a signed multiply by {0, gain} then scaled by 2^MW.
    localparam int unsigned MUL_W      = DW + MW + 1;
    localparam int unsigned GAIN_SHIFT = MW;
    localparam logic [MW-1:0] MOD_MAX  = '1;

    // Slewed depth state
    logic [DEPTH_W-1:0]     depth_s;
    logic [DEPTH_W-1:0]     depth_nxt_c;

    // Stage 1 registers
    logic                   s1_valid;
    logic signed [DW-1:0]   s1_sample;
    logic                   s1_bypass;
    logic [MW-1:0]          s1_att;

    // Stage 2 registers
    logic                   s2_valid;
    logic signed [DW-1:0]   s2_sample;
    logic                   s2_bypass;
    logic [MW-1:0]          s2_gain;

    // Combinational datapath terms
    logic [MW-1:0]          inv_mod_c;
    logic [ATT_PROD_W-1:0]  att_prod_c;
    logic [MW-1:0]          att_c;
    logic [MW-1:0]          gain_c;
    logic signed [MUL_W-1:0] mul_c;
    logic [DW-1:0]          scaled_c;

    // Depth moves one step toward the target, only on sample strobes
    always_comb begin
        depth_nxt_c = depth_s;
        if (sample_valid_i) begin
            if (depth_s < depth_i) begin
                depth_nxt_c = depth_s + DEPTH_W'(1);
            end else if (depth_s > depth_i) begin
                depth_nxt_c = depth_s - DEPTH_W'(1);
            end
        end
    end

    // Attenuation uses the depth value from before this sample's update
    always_comb begin
        inv_mod_c  = MOD_MAX - modulator_i;
        att_prod_c = ATT_PROD_W'(depth_s) * ATT_PROD_W'(inv_mod_c);
        att_c      = MW'(att_prod_c >> ATT_SHIFT);
    end

    // Gain is the complement of attenuation; att never exceeds 509
    always_comb begin
        gain_c = MOD_MAX - s1_att;
    end

    // Signed scale with arithmetic shift (floor), gain < 2^MW so no overflow
    always_comb begin
        mul_c    = MUL_W'(s2_sample) * MUL_W'($signed({1'b0, s2_gain}));
        scaled_c = DW'(mul_c >>> GAIN_SHIFT);
    end

    // Depth slew register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            depth_s <= '0;
        end else begin
            depth_s <= depth_nxt_c;
        end
    end

    // Stage 1: capture sample, bypass flag and attenuation
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_bypass <= 1'b0;
            s1_att    <= '0;
        end else begin
            s1_valid <= sample_valid_i;
            if (sample_valid_i) begin
                s1_sample <= sample_i;
                s1_bypass <= bypass_i;
                s1_att    <= att_c;
            end
        end
    end

    // Stage 2: convert attenuation to gain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid  <= 1'b0;
            s2_sample <= '0;
            s2_bypass <= 1'b0;
            s2_gain   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sample <= s1_sample;
                s2_bypass <= s1_bypass;
                s2_gain   <= gain_c;
            end
        end
    end

    // Stage 3: apply gain or pass through; output holds between strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
        end else begin
            sample_valid_o <= s2_valid;
            if (s2_valid) begin
                sample_o <= s2_bypass ? s2_sample : scaled_c;
            end
        end
    end

endmodule

// File: tb/tb_tremolo_vca.sv
// Bench for tremolo_vca: table vectors, directed corner sequences and random
// traffic scored against an arithmetic reference model with a timed queue.
module tb_tremolo_vca;

    logic        clk_i;
    logic        rst_n_i;
    logic        sample_valid_i;
    logic [15:0] sample_i;
    logic [8:0]  modulator_i;
    logic [7:0]  depth_i;
    logic        bypass_i;
    logic [15:0] sample_o;
    logic        sample_valid_o;

    tremolo_vca #(.DW(16), .MW(9), .DEPTH_W(8)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .modulator_i    (modulator_i),
        .depth_i        (depth_i),
        .bypass_i       (bypass_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic byp;
        int   smp;
        int   mod;
        int   dep;
        int   exp;
    } vec_t;

    typedef struct {
        int due;
        int val;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   md = 0;
    int   exp_last = 0;
    int   slew_exp[7] = '{-31488, -31616, -31744, -31872, -32000, -32128, -32128};

    // Reference: gain from the arithmetic definition, floor division by 512
    function automatic int model_out(input int d, input int m, input int s, input logic byp);
        int att, g, p;
        if (byp) return s;
        att = (d * (511 - m)) / 256;
        g   = 511 - att;
        p   = s * g;
        if (p >= 0) return p / 512;
        return -((-p + 511) / 512);
    endfunction

    task automatic check_out();
        checks++;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (sample_valid_o !== 1'b1 || sample_o !== 16'(q[0].val)) begin
                errors++;
                $display("FAIL out@cyc%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         cyc, sample_valid_o, $signed(sample_o), q[0].val);
            end
            exp_last = q[0].val;
            void'(q.pop_front());
        end else begin
            if (sample_valid_o !== 1'b0 || sample_o !== 16'(exp_last)) begin
                errors++;
                $display("FAIL idle@cyc%0d: got valid=%b data=%0d, want valid=0 data=%0d",
                         cyc, sample_valid_o, $signed(sample_o), exp_last);
            end
        end
    endtask

    // One clock of stimulus; ovr selects a hand-computed expected value
    task automatic step(input logic v, input logic byp, input int smp, input int mod,
                        input int dep, input logic ovr, input int ovr_val);
        exp_t e;
        sample_valid_i = v;
        bypass_i       = byp;
        sample_i       = 16'(smp);
        modulator_i    = 9'(mod);
        depth_i        = 8'(dep);
        if (v) begin
            e.due = cyc + 3;
            e.val = ovr ? ovr_val : model_out(md, mod, smp, byp);
            q.push_back(e);
            if (md < dep) md++;
            else if (md > dep) md--;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic rand_step(input int valid_pct, input int dep);
        int smp, mod;
        smp = int'($urandom_range(65535)) - 32768;
        case ($urandom_range(3))
            0: mod = 0;
            1: mod = 511;
            default: mod = int'($urandom_range(511));
        endcase
        step(($urandom_range(99) < valid_pct), ($urandom_range(7) == 0), smp, mod, dep, 1'b0, 0);
    endtask

    // Mid-cycle asynchronous reset, then synchronous release
    task automatic do_reset();
        sample_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (sample_valid_o !== 1'b0 || sample_o !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%0d, want valid=0 data=0",
                     sample_valid_o, $signed(sample_o));
        end
        q.delete();
        md = 0;
        exp_last = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
        check_out();
    endtask

    initial begin
        rst_n_i        = 1'b0;
        sample_valid_i = 1'b0;
        sample_i       = '0;
        modulator_i    = '0;
        depth_i        = '0;
        bypass_i       = 1'b0;

        vecs[0] = '{1'b1,  16384, 123, 0,  16384};
        vecs[1] = '{1'b0,  16384,   0, 0,  16352};
        vecs[2] = '{1'b0, -16384,   0, 0, -16352};
        vecs[3] = '{1'b0,   1000, 511, 0,    998};
        vecs[4] = '{1'b0,     -1,   0, 0,     -1};
        vecs[5] = '{1'b0,      1,   0, 0,      0};
        vecs[6] = '{1'b0,  32767, 300, 0,  32703};
        vecs[7] = '{1'b1, -32768, 0,   0, -32768};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc = 0;
        checks++;
        if (sample_valid_o !== 1'b0 || sample_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%0d, want valid=0 data=0",
                     sample_valid_o, $signed(sample_o));
        end

        // Table vectors at zero depth, each isolated
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].byp, vecs[i].smp, vecs[i].mod, vecs[i].dep, 1'b1, vecs[i].exp);
            idle(3);
        end

        // Full depth ramp: the 255th update lands exactly on 255
        do_reset();
        for (int i = 0; i < 254; i++) rand_step(100, 255);
        step(1'b1, 1'b0, -32768,   0, 255, 1'b1, -256);
        step(1'b1, 1'b0, -32768,   0, 255, 1'b1, -128);
        step(1'b1, 1'b0, -32768, 511, 255, 1'b1, -32704);
        idle(3);

        // Slew down from 10 to 5; idle cycles with a different target change nothing
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1000 * i - 4000, 77, 10, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, -32768, 0, 5, 1'b1, slew_exp[i]);
            step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
        end
        idle(3);

        // Streaming: 10 back-to-back then 3 with 2-cycle gaps, target jumping
        for (int i = 0; i < 10; i++) rand_step(100, int'($urandom_range(255)));
        for (int i = 0; i < 3; i++) begin
            rand_step(100, int'($urandom_range(255)));
            idle(2);
        end
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) rand_step(60, (i < 200) ? 200 : int'($urandom_range(255)));
        idle(3);

        // Reset with samples in flight; depth restarts from zero afterwards
        step(1'b1, 1'b1, 16'h1234, 0, 255, 1'b0, 0);
        step(1'b1, 1'b0, 5000, 10, 255, 1'b0, 0);
        step(1'b1, 1'b0, -7000, 20, 255, 1'b0, 0);
        do_reset();
        idle(5);
        step(1'b1, 1'b0, -32768, 0, 200, 1'b1, -32704);
        idle(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
